// File: rtl/obi_pkg.sv
// OBI bus types shared by the bus fabric.
//   obi_req_t  : master -> slave address/write phase
//   obi_resp_t : slave -> master grant and response phase
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/xbar_ot_pkg.sv
// Types and helpers for the N-to-1 OBI crossbar with outstanding transactions.
//   xbar_ot_arb_e : arbitration policy (round-robin or fixed lowest-index)
//   idx_w()       : master-index width, never less than one bit
package xbar_ot_pkg;

  typedef enum logic {
    XBAR_OT_ARB_RR,
    XBAR_OT_ARB_FIXED
  } xbar_ot_arb_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xbar_ot_id_fifo.sv
// In-order FIFO holding the master index of each granted, unanswered request.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an entry (ignored while full)
//   pop_i/data_o  : drop the head entry (ignored while empty); data_o is the head
//   full_o/empty_o: registered status flags
//   occ_o         : registered occupancy
module xbar_ot_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int unsigned PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Storage sized to the pointer range so any pointer value indexes legally.
  logic [WIDTH-1:0] mem_q [2**PW];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Payload needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign occ_o   = cnt_q;

endmodule

// File: rtl/obi_xbar_n_to_one_ot.sv
// N-to-1 OBI crossbar with up to MAX_OUTSTANDING granted-but-unanswered
// transactions. An in-order ID FIFO remembers which master owns each
// outstanding request and steers rvalid back to it; rdata is broadcast.
// Optional build macro: OBI_XBAR_N_TO_ONE_PERF_CNT_EN adds per-master 32-bit
// wrapping handshake counters on gnt_cnt_o (tied to 0 otherwise).
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   master_req_i   : requests from NUM_MASTERS masters
//   master_resp_o  : per-master gnt/rvalid, broadcast rdata
//   slave_req_o    : merged request toward the slave
//   slave_resp_i   : slave gnt/rvalid/rdata (responses in order)
//   busy_o         : at least one transaction outstanding
//   err_o          : sticky, rvalid seen with nothing outstanding
//   gnt_cnt_o      : per-master accepted-request counters
module obi_xbar_n_to_one_ot
  import xbar_ot_pkg::*;
#(
  parameter int unsigned  NUM_MASTERS     = 2,
  parameter int unsigned  MAX_OUTSTANDING = 2,
  parameter xbar_ot_arb_e ARB_MODE        = XBAR_OT_ARB_RR
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  obi_pkg::obi_req_t  [NUM_MASTERS-1:0] master_req_i,
  output obi_pkg::obi_resp_t [NUM_MASTERS-1:0] master_resp_o,
  output obi_pkg::obi_req_t                    slave_req_o,
  input  obi_pkg::obi_resp_t                   slave_resp_i,
  output logic                                 busy_o,
  output logic                                 err_o,
  output logic [NUM_MASTERS-1:0][31:0]         gnt_cnt_o
);

  localparam int unsigned IW = idx_w(NUM_MASTERS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] rr_q;
  logic          err_q;
  logic          hs;
  logic          pop;
  logic          full, empty;
  logic [IW-1:0] head;
  logic [CW-1:0] occ;

  // ---------------------------------------------------------------------------
  // Winner selection. A pending (ungranted) request keeps its master locked so
  // the address phase stays stable until the slave accepts it.
  // ---------------------------------------------------------------------------
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cidx;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    cidx    = '0;
    if (lock_q) begin
      win_idx = lock_idx_q;
      win_vld = master_req_i[lock_idx_q].req;
    end else begin
      for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
        if (ARB_MODE == XBAR_OT_ARB_RR) begin
          cand = 32'(rr_q);
          cand = (cand + off) % NUM_MASTERS;
        end else begin
          cand = off;
        end
        cidx = IW'(cand);
        if (!win_vld && master_req_i[cidx].req) begin
          win_vld = 1'b1;
          win_idx = cidx;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request path: payload follows the winner even while full holds req low.
  // ---------------------------------------------------------------------------
  always_comb begin
    slave_req_o = '0;
    if (win_vld) begin
      slave_req_o     = master_req_i[win_idx];
      slave_req_o.req = ~full;
    end
  end

  assign hs  = slave_req_o.req & slave_resp_i.gnt;
  assign pop = slave_resp_i.rvalid & ~empty;

  // ---------------------------------------------------------------------------
  // Response path: grant to the winner, rvalid to the FIFO head owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    master_resp_o = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      master_resp_o[i].gnt    = hs & (win_idx == IW'(i));
      master_resp_o[i].rvalid = pop & (head == IW'(i));
      master_resp_o[i].rdata  = slave_resp_i.rdata;
    end
  end

  xbar_ot_id_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .pop_i   (pop),
    .data_i  (win_idx),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .occ_o   (occ)
  );

  // ---------------------------------------------------------------------------
  // Lock, round-robin pointer, sticky error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        lock_q <= 1'b0;
      end else if (slave_req_o.req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end
      if (hs) begin
        rr_q <= (win_idx == IW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
      end
      if (slave_resp_i.rvalid && empty) err_q <= 1'b1;
    end
  end

  assign busy_o = (occ != '0);
  assign err_o  = err_q;

  // ---------------------------------------------------------------------------
  // Optional per-master handshake counters (wrap at 2^32).
  // ---------------------------------------------------------------------------
`ifdef OBI_XBAR_N_TO_ONE_PERF_CNT_EN
  logic [NUM_MASTERS-1:0][31:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (hs && (win_idx == IW'(i))) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign gnt_cnt_o = cnt_q;
`else
  assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_xbar_n_to_one_ot.sv
module tb_obi_xbar_n_to_one_ot;
  import obi_pkg::*;
  import xbar_ot_pkg::*;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT: RR, depth 2. Second DUT: FIXED, depth 1 (legacy blocking).
  obi_req_t  [1:0]  m_req, f_req;
  obi_resp_t [1:0]  m_resp, f_resp;
  obi_req_t         m_sreq, f_sreq;
  obi_resp_t        m_sresp, f_sresp;
  logic             m_busy, m_err, f_busy, f_err;
  logic [1:0][31:0] m_cnt, f_cnt;

  obi_xbar_n_to_one_ot #(.NUM_MASTERS(2), .MAX_OUTSTANDING(2), .ARB_MODE(XBAR_OT_ARB_RR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .master_req_i(m_req), .master_resp_o(m_resp),
    .slave_req_o(m_sreq), .slave_resp_i(m_sresp), .busy_o(m_busy), .err_o(m_err),
    .gnt_cnt_o(m_cnt));

  obi_xbar_n_to_one_ot #(.NUM_MASTERS(2), .MAX_OUTSTANDING(1), .ARB_MODE(XBAR_OT_ARB_FIXED)) dut_fix (
    .clk_i(clk), .rst_ni(rst_n), .master_req_i(f_req), .master_resp_o(f_resp),
    .slave_req_o(f_sreq), .slave_resp_i(f_sresp), .busy_o(f_busy), .err_o(f_err),
    .gnt_cnt_o(f_cnt));

  typedef struct {
    bit          sel;   // 0 = main DUT, 1 = fixed DUT
    bit          r0, r1, gnt, rv;
    logic [31:0] rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_g0, e_g1, e_v0, e_v1, e_busy;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(bit sel, bit r0, bit r1, bit gnt, bit rv, logic [31:0] rd,
                              bit e_req, logic [31:0] e_addr,
                              bit e_g0, bit e_g1, bit e_v0, bit e_v1, bit e_busy);
    vec_t v;
    v.sel = sel; v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_g0 = e_g0; v.e_g1 = e_g1;
    v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_busy = e_busy;
    return v;
  endfunction

  // M0 always writes, M1 always reads, so 'we' shows which master was muxed.
  function automatic obi_req_t mreq(bit r, logic [31:0] a, bit we);
    obi_req_t q;
    q = '0;
    if (r) begin
      q.req = 1'b1; q.we = we; q.be = 4'hF; q.addr = a; q.wdata = ~a;
    end
    return q;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    m_req = '0; f_req = '0; m_sresp = '0; f_sresp = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        v;
    obi_req_t    sq;
    obi_resp_t   [1:0] rs;
    logic        busy;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic [1:0][31:0] ecnt;

    // sel r0 r1 gnt rv rdata     | req addr g0 g1 v0 v1 busy
    // Round-robin fairness with rvalid one cycle after each grant.
    tbl.push_back(mk(0, 0,0, 0,0, 32'h0,       0, 32'h0, 0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,1, 1,0, 32'h0,       1, A0,    1,0, 0,0, 0));
    tbl.push_back(mk(0, 1,1, 1,1, 32'hAAAA_0001, 1, A1,  0,1, 1,0, 1));
    tbl.push_back(mk(0, 1,1, 1,1, 32'hBBBB_0002, 1, A0,  1,0, 0,1, 1));
    tbl.push_back(mk(0, 1,1, 1,1, 32'hCCCC_0003, 1, A1,  0,1, 1,0, 1));
    // Outstanding limit: responses withheld, FIFO fills to 2.
    tbl.push_back(mk(0, 1,1, 1,0, 32'h0,       1, A0,    1,0, 0,0, 1));
    tbl.push_back(mk(0, 1,1, 1,0, 32'h0,       0, A1,    0,0, 0,0, 1));
    // Pop while full: no push in the same cycle, push follows next cycle.
    tbl.push_back(mk(0, 1,1, 1,1, 32'hDDDD_0004, 0, A1,  0,0, 0,1, 1));
    tbl.push_back(mk(0, 1,1, 1,0, 32'h0,       1, A1,    0,1, 0,0, 1));
    tbl.push_back(mk(0, 0,0, 0,1, 32'hEEEE_0005, 0, 32'h0, 0,0, 1,0, 1));
    tbl.push_back(mk(0, 0,0, 0,1, 32'h1234_0006, 0, 32'h0, 0,0, 0,1, 1));
    tbl.push_back(mk(0, 0,0, 0,0, 32'h0,       0, 32'h0, 0,0, 0,0, 0));
    // Lock: rr_ptr moved to 1, M1 held for 3 ungranted cycles, then M0.
    tbl.push_back(mk(0, 1,0, 1,0, 32'h0,       1, A0,    1,0, 0,0, 0));
    tbl.push_back(mk(0, 1,1, 0,1, 32'h5555_0007, 1, A1,  0,0, 1,0, 1));
    tbl.push_back(mk(0, 1,1, 0,0, 32'h0,       1, A1,    0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,1, 0,0, 32'h0,       1, A1,    0,0, 0,0, 0));
    tbl.push_back(mk(0, 1,1, 1,0, 32'h0,       1, A1,    0,1, 0,0, 0));
    tbl.push_back(mk(0, 1,1, 1,1, 32'h6666_0008, 1, A0,  1,0, 0,1, 1));
    tbl.push_back(mk(0, 0,0, 0,1, 32'h7777_0009, 0, 32'h0, 0,0, 1,0, 1));
    // Fixed-priority, depth 1: lock beats the lower index, blocking behaviour.
    tbl.push_back(mk(1, 0,1, 0,0, 32'h0,       1, A1,    0,0, 0,0, 0));
    tbl.push_back(mk(1, 1,1, 0,0, 32'h0,       1, A1,    0,0, 0,0, 0));
    tbl.push_back(mk(1, 1,1, 1,0, 32'h0,       1, A1,    0,1, 0,0, 0));
    tbl.push_back(mk(1, 1,1, 1,0, 32'h0,       0, A0,    0,0, 0,0, 1));
    tbl.push_back(mk(1, 1,1, 1,1, 32'h8888_000A, 0, A0,  0,0, 0,1, 1));
    tbl.push_back(mk(1, 1,1, 1,0, 32'h0,       1, A0,    1,0, 0,0, 0));
    tbl.push_back(mk(1, 0,0, 0,1, 32'h9999_000B, 0, 32'h0, 0,0, 1,0, 1));

    // Reset state.
    idle_all();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("reset_req",  {255'd0, m_sreq.req}, 256'd0);
    chk("reset_busy", {255'd0, m_busy},     256'd0);
    chk("reset_err",  {255'd0, m_err},      256'd0);
    chk("reset_cnt",  {192'd0, m_cnt},      256'd0);
    cycle();

    foreach (tbl[i]) begin
      v = tbl[i];
      idle_all();
      if (v.sel == 1'b0) begin
        m_req[0] = mreq(v.r0, A0, 1'b1);
        m_req[1] = mreq(v.r1, A1, 1'b0);
        m_sresp  = '{gnt: v.gnt, rvalid: v.rv, rdata: v.rd};
      end else begin
        f_req[0] = mreq(v.r0, A0, 1'b1);
        f_req[1] = mreq(v.r1, A1, 1'b0);
        f_sresp  = '{gnt: v.gnt, rvalid: v.rv, rdata: v.rd};
      end
      #4;
      sq   = v.sel ? f_sreq : m_sreq;
      rs   = v.sel ? f_resp : m_resp;
      busy = v.sel ? f_busy : m_busy;
      ewd  = (v.e_addr != 32'h0) ? ~v.e_addr : 32'h0;
      ebe  = (v.e_addr != 32'h0) ? 4'hF : 4'h0;
      chk($sformatf("vec%0d", i),
          {sq.req, sq.addr, sq.we, sq.be, sq.wdata,
           rs[0].gnt, rs[1].gnt, rs[0].rvalid, rs[1].rvalid, busy,
           rs[0].rdata, rs[1].rdata},
          {v.e_req, v.e_addr, (v.e_addr == A0), ebe, ewd,
           v.e_g0, v.e_g1, v.e_v0, v.e_v1, v.e_busy, v.rd, v.rd});
      cycle();
    end

`ifdef OBI_XBAR_N_TO_ONE_PERF_CNT_EN
    ecnt = {32'd4, 32'd5};
`else
    ecnt = '0;
`endif
    chk("cnt_after_table", {192'd0, m_cnt}, {192'd0, ecnt});

    // Stray rvalid with nothing outstanding.
    idle_all();
    m_sresp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hDEAD_BEEF};
    #4;
    chk("err_no_rvalid", {254'd0, m_resp[0].rvalid, m_resp[1].rvalid}, 256'd0);
    cycle();
    idle_all();
    chk("err_set", {255'd0, m_err}, {255'd0, 1'b1});
    repeat (3) cycle();
    chk("err_sticky", {254'd0, m_err, m_busy}, {254'd0, 2'b10});

    // Mid-transaction reset: one outstanding M0 request, M1 locked pending.
    m_req[0] = mreq(1'b1, A0, 1'b1);
    m_sresp  = '{gnt: 1'b1, rvalid: 1'b0, rdata: 32'h0};
    cycle();
    m_req[1] = mreq(1'b1, A1, 1'b0);
    m_sresp  = '0;
    #4;
    chk("pre_rst_addr", {224'd0, m_sreq.addr}, {224'd0, A1});
    cycle();
    idle_all();
    rst_n = 1'b0;
    #1;
    chk("rst_busy_err", {254'd0, m_busy, m_err}, 256'd0);
    chk("rst_cnt",      {192'd0, m_cnt},         256'd0);
    #1;
    rst_n = 1'b1;
    m_req[0] = mreq(1'b1, A0, 1'b1);
    m_req[1] = mreq(1'b1, A1, 1'b0);
    #2;
    chk("post_rst_winner", {223'd0, m_sreq.req, m_sreq.addr}, {223'd0, 1'b1, A0});
    cycle();
    idle_all();
    cycle();

`ifdef OBI_XBAR_N_TO_ONE_PERF_CNT_EN
    // Counter wrap: preload M0 counter to all ones, one M0 handshake.
    #3;
    force dut.cnt_q = {32'd0, 32'hFFFF_FFFF};
    #1;
    release dut.cnt_q;
    cycle();
    m_req[0] = mreq(1'b1, A0, 1'b1);
    m_sresp  = '{gnt: 1'b1, rvalid: 1'b0, rdata: 32'h0};
    cycle();
    idle_all();
    chk("cnt_wrap", {192'd0, m_cnt}, 256'd0);
    m_sresp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'h0};
    cycle();
    idle_all();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/obi_xbar_n_to_one_ot.md
# obi_xbar_n_to_one_ot

N-to-1 OBI crossbar that merges `NUM_MASTERS` OBI master ports onto one OBI slave port and allows up to `MAX_OUTSTANDING` granted-but-unanswered transactions. It generalises the blocking N-to-1 crossbar in the bus fabric, which allows only one outstanding transaction. An in-order ID FIFO records the master of each granted request and routes each `rvalid`/`rdata` back to that master. Selectable arbitration, grant locking and a protocol-error flag complete the block.

## Interface
- `NUM_MASTERS`, default 2: number of master ports, ≥1.
- `MAX_OUTSTANDING`, default 2: ID FIFO depth, ≥1. A value of 1 gives the legacy blocking behaviour.
- `ARB_MODE`, default `XBAR_OT_ARB_RR`: `XBAR_OT_ARB_RR` (round-robin) or `XBAR_OT_ARB_FIXED` (lowest index wins).
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `master_req_i` in, `obi_pkg::obi_req_t [NUM_MASTERS]`: master requests.
- `master_resp_o` out, `obi_pkg::obi_resp_t [NUM_MASTERS]`: master responses.
- `slave_req_o` out, `obi_pkg::obi_req_t`: merged request.
- `slave_resp_i` in, `obi_pkg::obi_resp_t`: slave response. The slave returns responses in order.
- `busy_o` out, 1: high when at least one transaction is outstanding.
- `err_o` out, 1: sticky protocol error.
- `gnt_cnt_o` out, `[NUM_MASTERS][31:0]`: per-master accepted-request counters.

## Operation
- **Definitions.**
  - `full` = registered occupancy equals `MAX_OUTSTANDING`.
  - Handshake = `slave_req_o.req & slave_resp_i.gnt`.
- **Winner selection.**
  - With no lock active, the winner is the first requesting master, scanning from `rr_ptr` in RR mode or from index 0 in FIXED mode.
  - With a lock active, the winner is the locked index.
- **Request path.**
  - `slave_req_o.req` = (any winner) & !`full`.
  - `we`, `be`, `addr` and `wdata` are muxed from the winner. When there is no winner they are 0.
  - `master_resp_o[w].gnt` = `slave_resp_i.gnt` & `slave_req_o.req`, for the winner only. All other grants are 0.
- **Lock.**
  - Set when `slave_req_o.req` is high with no grant; it stores the winner index.
  - Cleared on the next handshake.
  - The stored winner is held even while `full` suppresses the request. This keeps the OBI address phase stable.
- **RR pointer.** On a handshake `rr_ptr` becomes (winner+1) mod `NUM_MASTERS`. Otherwise it is unchanged.
- **Push.** Each handshake pushes the winner index into the ID FIFO.
- **Response.**
  - `slave_resp_i.rvalid` with the FIFO non-empty pops the head.
  - It drives `master_resp_o[head].rvalid` = 1; all other masters' `rvalid` = 0.
  - `rdata` is broadcast to all masters.
- **Simultaneous push and pop.**
  - Allowed whenever not `full`; occupancy is unchanged.
  - When `full`, a pop in a cycle does not enable a push in the same cycle, because `full` is registered. The push happens in the next cycle.
- **Error.**
  - `rvalid` with the FIFO empty: no master sees `rvalid`, and `err_o` is set.
  - `err_o` clears only on reset.
- **Busy.** `busy_o` = occupancy ≠ 0.
- **Reset.**
  - Asserting `rst_ni` mid-transaction empties the FIFO, clears the lock and sets `rr_ptr` to 0. Outstanding responses are lost.
  - After reset: `busy_o` = 0, `err_o` = 0, counters = 0. All `gnt` and `rvalid` are 0 unless driven by the combinational rules above from inputs.

## Timing
- The request path has zero latency: `req`/`gnt` are combinational from inputs and the registered state.
- The response path has zero latency: `rvalid` routing is combinational from the FIFO head.
- The FIFO, occupancy, lock, `rr_ptr`, `err_o` and counters update on the rising edge of `clk_i`.
- Throughput is one handshake per cycle while occupancy < `MAX_OUTSTANDING`, or while the pop rules above keep it below that limit.

## Configuration
- `OBI_XBAR_N_TO_ONE_PERF_CNT_EN` defined:
  - `gnt_cnt_o[i]` increments by 1 on each handshake won by master i.
  - Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: `gnt_cnt_o` is tied to 0 and no counter flops are generated.

## Structure
- Package `xbar_ot_pkg`:
  - Enum `xbar_ot_arb_e` with values `XBAR_OT_ARB_RR` and `XBAR_OT_ARB_FIXED`.
  - Helper function for the master-index width, `$clog2(NUM_MASTERS)` with a minimum of 1.
- Sub-module `xbar_ot_id_fifo`:
  - Parameters: width and depth.
  - Ports: push, pop, data in, data out.
  - Outputs: registered `full`/`empty` and occupancy.
  - Pointers wrap at depth.

## Test plan
- **Reset state.** N=2, depth=2; reset with inputs idle. Expect `slave_req_o.req`=0, `busy_o`=0, `err_o`=0, `gnt_cnt_o`=0.
- **RR fairness.** Both masters request continuously; slave grants every cycle and returns `rvalid` one cycle later. Expect grant order M0, M1, M0, M1 and each `rvalid` delivered to the matching master with the correct `rdata`.
- **Outstanding limit.**
  - Depth=2, slave grants but withholds `rvalid`. Expect two handshakes, then `slave_req_o.req`=0 and `busy_o`=1.
  - After one `rvalid`, expect a new handshake in the following cycle, not the same cycle.
- **Lock.** M1 wins with slave `gnt`=0 for 3 cycles while M0 also requests in RR mode with `rr_ptr`=1. Expect `addr` to stay at M1's value until the grant, then M0 is served.
- **Error.** `rvalid` pulse with the FIFO empty. Expect all master `rvalid`=0 and `err_o`=1, held until reset.
- **Counter wrap.** With `OBI_XBAR_N_TO_ONE_PERF_CNT_EN`, preload via forced state to 0xFFFFFFFF and perform one M0 handshake. Expect `gnt_cnt_o[0]`=0.
